// File: rtl/seq_div.sv
// Non-restoring multi-cycle divider, signed or unsigned. One add/sub step per clock.
// Result appears WIDTH+2 edges after accept. A start request while busy is dropped, not queued.
module seq_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

    state_t           state_q;
    logic             sgn_q;
    logic [WIDTH-1:0] dvd_q, dvs_q, dabs_q, q_q;
    logic [WIDTH:0]   p_q;
    logic [CW-1:0]    cnt_q;
    logic             sign_q_q, sign_r_q;
    logic             busy_q, done_q, dz_q, ovf_q;
    logic [WIDTH-1:0] quo_q, rem_q;

    logic             dvd_neg, dvs_neg;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic             sub;
    logic [WIDTH:0]   alu_a, alu_b, p_d;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] rmag, quo_d, rem_d;
    logic             dz_d, ovf_d;

    always_comb begin
        dvd_neg = sgn_q & dvd_q[WIDTH-1];
        dvs_neg = sgn_q & dvs_q[WIDTH-1];
        dvd_mag = dvd_neg ? -dvd_q : dvd_q;
        dvs_mag = dvs_neg ? -dvs_q : dvs_q;
    end

    // Same shape as the ALU add/sub stage: invert B and carry in 1 to subtract.
    always_comb begin
        sub   = ~p_q[WIDTH];
        alu_a = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
        alu_b = {1'b0, dabs_q} ^ {(WIDTH+1){sub}};
        p_d   = alu_a + alu_b + {{WIDTH{1'b0}}, sub};
        q_d   = {q_q[WIDTH-2:0], ~p_d[WIDTH]};
    end

    // Final remainder magnitude is below |divisor|, so WIDTH bits are enough.
    always_comb begin
        rmag  = p_q[WIDTH-1:0] + (p_q[WIDTH] ? dabs_q : '0);
        quo_d = sign_q_q ? -q_q : q_q;
        rem_d = sign_r_q ? -rmag : rmag;
        dz_d  = (dvs_q == '0);
        ovf_d = sgn_q & (dvd_q == MIN_VAL) & (dvs_q == '1);
        if (dz_d) begin
            quo_d = '1;
            rem_d = dvd_q;
            ovf_d = 1'b0;
        end else if (ovf_d) begin
            quo_d = MIN_VAL;
            rem_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sgn_q    <= 1'b0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            dabs_q   <= '0;
            q_q      <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            quo_q    <= '0;
            rem_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        sgn_q   <= is_signed;
                        dvd_q   <= dividend;
                        dvs_q   <= divisor;
                        quo_q   <= '0;
                        rem_q   <= '0;
                        dz_q    <= 1'b0;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_PREP;
                    end
                end
                S_PREP: begin
                    q_q      <= dvd_mag;
                    dabs_q   <= dvs_mag;
                    p_q      <= '0;
                    cnt_q    <= CW'(WIDTH - 1);
                    sign_q_q <= dvd_neg ^ dvs_neg;
                    sign_r_q <= dvd_neg;
                    state_q  <= S_ITER;
                end
                S_ITER: begin
                    p_q   <= p_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    quo_q   <= quo_d;
                    rem_q   <= rem_d;
                    dz_q    <= dz_d;
                    ovf_q   <= ovf_d;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign div_zero  = dz_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_seq_div.sv
// Directed and randomised checks of seq_div at WIDTH=32.
module tb_seq_div;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          is_signed;
    logic [W-1:0]  dividend;
    logic [W-1:0]  divisor;
    logic          busy;
    logic          done;
    logic [W-1:0]  quotient;
    logic [W-1:0]  remainder;
    logic          div_zero;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_div #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .overflow  (overflow)
    );

    // Called just after a rising edge; returns just after the edge where busy falls.
    task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit hold,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic dz, output logic ov,
                          output int bcnt, output int ndone);
        int lat;
        lat = -1; bcnt = 0; ndone = 0;
        start = 1'b1; is_signed = s; dividend = a; divisor = b;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        if (busy) bcnt++;
        for (int k = 1; k <= 100; k++) begin
            if (hold && k == 5) begin
                dividend = 32'h5; divisor = 32'h3; is_signed = ~s;
            end
            @(posedge clk); #1;
            if (busy) bcnt++;
            if (done) begin
                ndone++;
                lat = k;
            end
            if (!busy) break;
        end
        start = 1'b0;
        q = quotient; r = remainder; dz = div_zero; ov = overflow;
        checks++;
        if (lat !== W + 2) begin
            errors++;
            $display("FAIL latency: got %0d edges, expected %0d", lat, W + 2);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, div_zero, overflow, quotient, remainder} !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b q=%h r=%h dz=%b ov=%b, expected all 0",
                     busy, done, quotient, remainder, div_zero, overflow);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned_basic();
        logic [W-1:0] q, r; logic dz, ov; int bc, nd;
        run_op(1'b0, 32'd100, 32'd7, 1'b0, q, r, dz, ov, bc, nd);
        checks++;
        if ({q, r, dz, ov} !== {32'd14, 32'd2, 2'b00}) begin
            errors++;
            $display("FAIL u100_7: got q=%h r=%h dz=%b ov=%b, expected q=e r=2 flags 0", q, r, dz, ov);
        end
        checks++;
        if (bc !== 35 || nd !== 1) begin
            errors++;
            $display("FAIL busy_len: got busy=%0d done=%0d, expected 35 and 1", bc, nd);
        end
    endtask

    task automatic test_signs();
        logic [W-1:0] q, r; logic dz, ov; int bc, nd;
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, q, r, dz, ov, bc, nd);
        checks++;
        if ({q, r} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL s_m7_2: got q=%h r=%h, expected fffffffd ffffffff", q, r);
        end
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, q, r, dz, ov, bc, nd);
        checks++;
        if ({q, r} !== {32'hFFFF_FFFD, 32'd1}) begin
            errors++;
            $display("FAIL s_7_m2: got q=%h r=%h, expected fffffffd 00000001", q, r);
        end
        run_op(1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0, q, r, dz, ov, bc, nd);
        checks++;
        if ({q, r} !== {32'h7FFF_FFFC, 32'd1}) begin
            errors++;
            $display("FAIL u_fff9_2: got q=%h r=%h, expected 7ffffffc 00000001", q, r);
        end
    endtask

    task automatic test_div_zero();
        logic [W-1:0] q, r; logic dz, ov; int bc, nd;
        for (int m = 0; m < 2; m++) begin
            run_op(m == 0, 32'h8000_0005, 32'd0, 1'b0, q, r, dz, ov, bc, nd);
            checks++;
            if ({q, r, dz, ov} !== {32'hFFFF_FFFF, 32'h8000_0005, 2'b10}) begin
                errors++;
                $display("FAIL div_zero(signed=%0d): got q=%h r=%h dz=%b ov=%b, expected ffffffff 80000005 1 0",
                         m == 0, q, r, dz, ov);
            end
        end
    endtask

    task automatic test_overflow();
        logic [W-1:0] q, r; logic dz, ov; int bc, nd;
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, q, r, dz, ov, bc, nd);
        checks++;
        if ({q, r, dz, ov} !== {32'h8000_0000, 32'd0, 2'b01}) begin
            errors++;
            $display("FAIL overflow_s: got q=%h r=%h dz=%b ov=%b, expected 80000000 0 0 1", q, r, dz, ov);
        end
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, q, r, dz, ov, bc, nd);
        checks++;
        if ({q, r, dz, ov} !== {32'd0, 32'h8000_0000, 2'b00}) begin
            errors++;
            $display("FAIL overflow_u: got q=%h r=%h dz=%b ov=%b, expected 0 80000000 0 0", q, r, dz, ov);
        end
    endtask

    task automatic test_hold_start();
        logic [W-1:0] q, r; logic dz, ov; int bc, nd, extra;
        run_op(1'b0, 32'd1000, 32'd10, 1'b1, q, r, dz, ov, bc, nd);
        extra = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (done || busy) extra++;
        end
        checks++;
        if ({q, r} !== {32'd100, 32'd0} || nd !== 1) begin
            errors++;
            $display("FAIL hold_start: got q=%h r=%h dones=%0d, expected 64 0 1", q, r, nd);
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL start_in_done: got %0d busy/done cycles after op, expected 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] q, r; logic dz, ov; int bc, nd;
        run_op(1'b0, 32'd50, 32'd6, 1'b0, q, r, dz, ov, bc, nd);
        run_op(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0, q, r, dz, ov, bc, nd);
        checks++;
        if ({q, r} !== {32'hFFFF_FFF2, 32'hFFFF_FFFE} || bc !== 35) begin
            errors++;
            $display("FAIL back_to_back: got q=%h r=%h busy=%0d, expected fffffff2 fffffffe 35", q, r, bc);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [W-1:0] q, r; logic dz, ov; int bc, nd;
        start = 1'b1; is_signed = 1'b0; dividend = 32'd12345; divisor = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #3;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_mid_op: got %b, expected 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, div_zero, overflow, quotient, remainder} !== '0) begin
            errors++;
            $display("FAIL async_reset: got busy=%b done=%b q=%h r=%h, expected all 0",
                     busy, done, quotient, remainder);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(1'b0, 32'd1000, 32'd10, 1'b0, q, r, dz, ov, bc, nd);
        checks++;
        if ({q, r, dz, ov} !== {32'd100, 32'd0, 2'b00}) begin
            errors++;
            $display("FAIL after_reset: got q=%h r=%h, expected 64 0", q, r);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, q, r, eq, er; logic s, dz, ov; int bc, nd;
        for (int i = 0; i < 20; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = (i % 2 == 1) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (s && i % 4 == 1) b = -b;
            if (b == '0) b = 32'd1;
            if (s && a == 32'h8000_0000 && b == '1) b = 32'd3;
            if (s) begin
                eq = 32'($signed(a) / $signed(b));
                er = 32'($signed(a) % $signed(b));
            end else begin
                eq = a / b;
                er = a % b;
            end
            run_op(s, a, b, 1'b0, q, r, dz, ov, bc, nd);
            checks++;
            if ({q, r, dz, ov} !== {eq, er, 2'b00}) begin
                errors++;
                $display("FAIL random[%0d] s=%b %h/%h: got q=%h r=%h, expected q=%h r=%h",
                         i, s, a, b, q, r, eq, er);
            end
            checks++;
            if (32'(q * b + r) !== a) begin
                errors++;
                $display("FAIL identity[%0d]: got q*b+r=%h, expected %h", i, 32'(q * b + r), a);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_basic();
        test_signs();
        test_div_zero();
        test_overflow();
        test_hold_start();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_div.md
Name: seq_div

Overview:
- Multi-cycle signed/unsigned integer divider for the ALU datapath.
- Runs a non-restoring algorithm, one add-or-subtract step per clock. Each step is the same operation as the ALU's WIDTH-bit add/sub stage: B is inverted when subtracting, with carry-in equal to the subtract flag.
- Takes latched operands from the execute stage and returns quotient and remainder with a one-cycle done strobe to the writeback mux.

Parameters:
- WIDTH, 32, operand, quotient and remainder width in bits (minimum 4).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; accepted only in IDLE.
- is_signed  input  1  1 = two's-complement division, 0 = unsigned; sampled with start.
- dividend  input  WIDTH  numerator; sampled with start.
- divisor  input  WIDTH  denominator; sampled with start.
- busy  output  1  high from the accept edge until the done cycle ends.
- done  output  1  one-cycle result-valid strobe.
- quotient  output  WIDTH  registered quotient; held until the next accept.
- remainder  output  WIDTH  registered remainder; held until the next accept.
- div_zero  output  1  divisor was 0; valid with done, held.
- overflow  output  1  signed -2^(WIDTH-1) / -1; valid with done, held.

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - State goes to IDLE.
  - busy, done, quotient, remainder, div_zero and overflow are all 0.
  - An operation in flight is aborted with no done.
- States: IDLE -> PREP -> ITER -> FIX -> DONE -> IDLE.
- IDLE: on a rising edge with start=1:
  - Latch is_signed, dividend and divisor.
  - Clear quotient, remainder, div_zero and overflow.
  - busy=1; go to PREP.
  - Operand changes after the accept edge are ignored.
- PREP (1 cycle):
  - Form magnitudes: negate a negative operand when is_signed=1; pass unchanged when unsigned.
  - Record sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
  - Clear the WIDTH+1-bit partial remainder; load a WIDTH-1 iteration counter.
- ITER (exactly WIDTH cycles):
  - Shift {P,Q} left one bit.
  - If P >= 0, P = P - |divisor|; otherwise P = P + |divisor|.
  - The new Q LSB is the inverse of P's sign.
  - Add/sub is WIDTH+1 bits wide with no saturation.
  - The counter decrements each cycle; leave ITER when it reaches 0.
- FIX (1 cycle), checked in this order:
  - If P < 0, P = P + |divisor|.
  - Apply signs: negate Q if sign_q, and negate P if sign_r (signed mode only).
  - Divisor == 0: quotient = all ones, remainder = original dividend, div_zero=1. This applies in both modes and overrides sign fix-up.
  - Signed, dividend = -2^(WIDTH-1) and divisor = -1: quotient = -2^(WIDTH-1), remainder = 0, overflow=1.
  - Results are written to the output registers on the FIX->DONE edge.
- DONE (1 cycle):
  - done=1 and busy=1; the next edge goes to IDLE with busy=0.
  - start is ignored in DONE.
  - Latency: accept edge E0, done high for the cycle following edge E0+WIDTH+2 (WIDTH=32: 34 edges). Latency is fixed regardless of operand values.
- start while busy: ignored, with no queuing and no effect on the operation in progress.
- Results: truncating division.
  - The remainder has the dividend's sign, or is 0.
  - |remainder| < |divisor| whenever divisor != 0.
  - dividend = quotient*divisor + remainder (mod 2^WIDTH) for all non-zero divisors.

Test Plan:
- Unsigned 100 / 7: start pulse at E0 -> done only in the cycle after E0+34; quotient=14, remainder=2, flags=0; busy high for exactly 35 cycles.
- Signed -7 / 2: quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Repeat with 7 / -2 -> quotient=-3, remainder=+1. Unsigned 0xFFFFFFF9 / 2 -> quotient=0x7FFFFFFC, remainder=1.
- Divide by zero: signed 0x80000005 / 0 -> quotient=0xFFFFFFFF, remainder=0x80000005, div_zero=1; identical result unsigned.
- Overflow: signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, overflow=1, div_zero=0. The same operands unsigned give quotient=0, remainder=0x80000000, flags=0.
- Handshake:
  - start held high through a whole operation with operands changed mid-run -> exactly one done, with results for the originally latched operands.
  - start high during the DONE cycle is ignored.
  - A start on the first IDLE cycle is accepted.
- Reset mid-operation: assert rst_n=0 asynchronously at iteration 10 -> all outputs 0 immediately with no clock edge needed. Release, then run 1000 / 10 -> quotient=100, remainder=0 with normal latency. Random signed/unsigned regression checks the identity and the remainder bounds against a reference model.
